// File: rtl/cpu_types_pkg.sv
// Shared pipeline types: latch commands, hazard FSM states and the load-use check.
package cpu_types_pkg;

  typedef enum logic [1:0] {
    PIPE_ENABLE = 2'd0,
    PIPE_STALL  = 2'd1,
    PIPE_NOP    = 2'd2
  } pipe_state_t;

  typedef enum logic [1:0] {
    HZ_RUN        = 2'd0,
    HZ_REDIR_WAIT = 2'd1,
    HZ_DRAIN      = 2'd2,
    HZ_HALTED     = 2'd3
  } hz_state_t;

  typedef logic [4:0] regbits_t;

  // $0 is hardwired to zero, so a load targeting it never creates a hazard.
  function automatic logic is_load_use(logic dren_ex, regbits_t rt_ex, regbits_t rs_dec,
                                       regbits_t rt_dec);
    return dren_ex && (rt_ex != '0) && ((rt_ex == rs_dec) || (rt_ex == rt_dec));
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Datapath <-> hazard controller bundle; master is the datapath, slave the controller.
interface pipeline_hazard_ctrl_if #(
  parameter int unsigned STALL_CNT_W = 32
);
  logic                     ihit;
  logic                     dhit;
  logic                     dREN_mem;
  logic                     dWEN_mem;
  logic                     dREN_ex;
  logic [4:0]               rt_ex;
  logic [4:0]               rs_dec;
  logic [4:0]               rt_dec;
  logic                     redirect_ex;
  logic                     halt_mem;
  cpu_types_pkg::pipe_state_t fd_state;
  cpu_types_pkg::pipe_state_t de_state;
  cpu_types_pkg::pipe_state_t em_state;
  cpu_types_pkg::pipe_state_t mw_state;
  logic                     pc_en;
  logic                     halt;
  logic [STALL_CNT_W-1:0]   stall_cnt;
  logic [STALL_CNT_W-1:0]   flush_cnt;

  modport master (
    output ihit, dhit, dREN_mem, dWEN_mem, dREN_ex, rt_ex, rs_dec, rt_dec, redirect_ex,
           halt_mem,
    input  fd_state, de_state, em_state, mw_state, pc_en, halt, stall_cnt, flush_cnt
  );

  modport slave (
    input  ihit, dhit, dREN_mem, dWEN_mem, dREN_ex, rt_ex, rs_dec, rt_dec, redirect_ex,
           halt_mem,
    output fd_state, de_state, em_state, mw_state, pc_en, halt, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_perf_counter.sv
// Saturating event counter with increment enable.
module hazard_perf_counter #(
  parameter int unsigned W = 32
) (
  input  logic         CLK,
  input  logic         nRST,
  input  logic         inc,
  output logic [W-1:0] count
);
  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != '1)) count_d = count_q + W'(1);
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) count_q <= '0;
    else       count_q <= count_d;
  end

  assign count = count_q;
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Five-stage pipeline controller: latch commands, PC enable, halt and stall/flush counters.
module pipeline_hazard_ctrl import cpu_types_pkg::*; #(
  parameter int unsigned STALL_CNT_W = 32
) (
  input logic                   CLK,
  input logic                   nRST,
  pipeline_hazard_ctrl_if.slave hz
);
  hz_state_t   state_q, state_d;
  logic        halt_q;
  logic        dwait, loaduse;
  logic        stall_inc, flush_inc;
  pipe_state_t fd, de, em, mw;
  logic        pc_en;
  logic [STALL_CNT_W-1:0] stall_cnt, flush_cnt;

  assign dwait   = (hz.dREN_mem || hz.dWEN_mem) && !hz.dhit;
  assign loaduse = is_load_use(hz.dREN_ex, hz.rt_ex, hz.rs_dec, hz.rt_dec);

  always_comb begin
    state_d   = state_q;
    fd        = PIPE_ENABLE;
    de        = PIPE_ENABLE;
    em        = PIPE_ENABLE;
    mw        = PIPE_ENABLE;
    pc_en     = 1'b1;
    stall_inc = 1'b0;
    flush_inc = 1'b0;
    case (state_q)
      HZ_RUN, HZ_REDIR_WAIT: begin
        if (dwait) begin
          // A pending redirect stays parked in EX until the data access finishes.
          fd = PIPE_STALL; de = PIPE_STALL; em = PIPE_STALL; mw = PIPE_NOP;
          pc_en     = 1'b0;
          stall_inc = 1'b1;
        end else if (hz.halt_mem) begin
          fd = PIPE_NOP; de = PIPE_NOP;
          pc_en   = 1'b0;
          state_d = HZ_DRAIN;
        end else if (state_q == HZ_REDIR_WAIT) begin
          fd = PIPE_NOP; de = PIPE_NOP;
          pc_en = hz.ihit;
          if (hz.ihit) state_d = HZ_RUN;
        end else if (hz.redirect_ex) begin
          fd = PIPE_NOP; de = PIPE_NOP;
          flush_inc = 1'b1;
          if (!hz.ihit) state_d = HZ_REDIR_WAIT;
        end else if (loaduse) begin
          fd = PIPE_STALL; de = PIPE_NOP;
          pc_en     = 1'b0;
          stall_inc = 1'b1;
        end else if (!hz.ihit) begin
          fd = PIPE_NOP;
          pc_en     = 1'b0;
          stall_inc = 1'b1;
        end
      end
      HZ_DRAIN: begin
        fd = PIPE_NOP; de = PIPE_NOP; em = PIPE_NOP;
        pc_en   = 1'b0;
        state_d = HZ_HALTED;
      end
      HZ_HALTED: begin
        fd = PIPE_STALL; de = PIPE_STALL; em = PIPE_STALL; mw = PIPE_STALL;
        pc_en = 1'b0;
      end
      default: state_d = HZ_RUN;
    endcase
    // Outputs follow reset combinationally so the pipe is quiesced while nRST is held.
    if (!nRST) begin
      fd = PIPE_NOP; de = PIPE_NOP; em = PIPE_NOP; mw = PIPE_NOP;
      pc_en     = 1'b0;
      stall_inc = 1'b0;
      flush_inc = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= HZ_RUN;
      halt_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == HZ_DRAIN) halt_q <= 1'b1;
    end
  end

  hazard_perf_counter #(.W(STALL_CNT_W)) u_stall_cnt (
    .CLK   (CLK),
    .nRST  (nRST),
    .inc   (stall_inc),
    .count (stall_cnt)
  );

  hazard_perf_counter #(.W(STALL_CNT_W)) u_flush_cnt (
    .CLK   (CLK),
    .nRST  (nRST),
    .inc   (flush_inc),
    .count (flush_cnt)
  );

  assign hz.fd_state  = fd;
  assign hz.de_state  = de;
  assign hz.em_state  = em;
  assign hz.mw_state  = mw;
  assign hz.pc_en     = pc_en;
  assign hz.halt      = halt_q;
  assign hz.stall_cnt = stall_cnt;
  assign hz.flush_cnt = flush_cnt;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench: per-cycle behavioural model check plus hand-computed literal checks.
module tb_pipeline_hazard_ctrl;
  import cpu_types_pkg::*;

  localparam int unsigned W    = 4;
  localparam int          MAXC = 15;

  logic CLK  = 1'b0;
  logic nRST = 1'b0;
  always #5 CLK = ~CLK;

  pipeline_hazard_ctrl_if #(.STALL_CNT_W(W)) hz ();

  pipeline_hazard_ctrl #(.STALL_CNT_W(W)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .hz   (hz)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0d, want %0d", name, $time, act, exp);
    end
  endtask

  // Model state: plain flags and integer counts.
  bit m_halted, m_draining, m_pending;
  int m_stall, m_flush;
  bit n_halted, n_draining, n_pending;
  int n_stall, n_flush;
  pipe_state_t e_fd, e_de, e_em, e_mw;
  logic e_pc;

  function automatic int sat(input int v);
    return (v >= MAXC) ? MAXC : v + 1;
  endfunction

  task automatic set_exp(input pipe_state_t f, input pipe_state_t d, input pipe_state_t e,
                         input pipe_state_t m, input logic p);
    e_fd = f; e_de = d; e_em = e; e_mw = m; e_pc = p;
  endtask

  always @(negedge CLK) begin
    bit dw, lu;
    n_halted = m_halted; n_draining = m_draining; n_pending = m_pending;
    n_stall = m_stall; n_flush = m_flush;
    dw = (hz.dREN_mem || hz.dWEN_mem) && !hz.dhit;
    lu = hz.dREN_ex && hz.rt_ex != 0 && (hz.rt_ex == hz.rs_dec || hz.rt_ex == hz.rt_dec);
    if (!nRST) begin
      set_exp(PIPE_NOP, PIPE_NOP, PIPE_NOP, PIPE_NOP, 1'b0);
    end else if (m_halted) begin
      set_exp(PIPE_STALL, PIPE_STALL, PIPE_STALL, PIPE_STALL, 1'b0);
    end else if (m_draining) begin
      set_exp(PIPE_NOP, PIPE_NOP, PIPE_NOP, PIPE_ENABLE, 1'b0);
      n_draining = 0; n_halted = 1;
    end else if (dw) begin
      set_exp(PIPE_STALL, PIPE_STALL, PIPE_STALL, PIPE_NOP, 1'b0);
      n_stall = sat(m_stall);
    end else if (hz.halt_mem) begin
      set_exp(PIPE_NOP, PIPE_NOP, PIPE_ENABLE, PIPE_ENABLE, 1'b0);
      n_draining = 1; n_pending = 0;
    end else if (m_pending) begin
      set_exp(PIPE_NOP, PIPE_NOP, PIPE_ENABLE, PIPE_ENABLE, hz.ihit);
      if (hz.ihit) n_pending = 0;
    end else if (hz.redirect_ex) begin
      set_exp(PIPE_NOP, PIPE_NOP, PIPE_ENABLE, PIPE_ENABLE, 1'b1);
      n_flush = sat(m_flush);
      n_pending = !hz.ihit;
    end else if (lu) begin
      set_exp(PIPE_STALL, PIPE_NOP, PIPE_ENABLE, PIPE_ENABLE, 1'b0);
      n_stall = sat(m_stall);
    end else if (!hz.ihit) begin
      set_exp(PIPE_NOP, PIPE_ENABLE, PIPE_ENABLE, PIPE_ENABLE, 1'b0);
      n_stall = sat(m_stall);
    end else begin
      set_exp(PIPE_ENABLE, PIPE_ENABLE, PIPE_ENABLE, PIPE_ENABLE, 1'b1);
    end
    chk("model_fd", hz.fd_state, e_fd);
    chk("model_de", hz.de_state, e_de);
    chk("model_em", hz.em_state, e_em);
    chk("model_mw", hz.mw_state, e_mw);
    chk("model_pc_en", hz.pc_en, e_pc);
    chk("model_halt", hz.halt, m_halted);
    chk("model_stall_cnt", hz.stall_cnt, m_stall);
    chk("model_flush_cnt", hz.flush_cnt, m_flush);
  end

  always @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      m_halted <= 0; m_draining <= 0; m_pending <= 0; m_stall <= 0; m_flush <= 0;
    end else begin
      m_halted <= n_halted; m_draining <= n_draining; m_pending <= n_pending;
      m_stall <= n_stall; m_flush <= n_flush;
    end
  end

  task automatic idle();
    hz.ihit = 1'b1; hz.dhit = 1'b0; hz.dREN_mem = 1'b0; hz.dWEN_mem = 1'b0;
    hz.dREN_ex = 1'b0; hz.rt_ex = '0; hz.rs_dec = '0; hz.rt_dec = '0;
    hz.redirect_ex = 1'b0; hz.halt_mem = 1'b0;
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    idle();
    nRST = 1'b0;
    #2;
    chk("rst_fd_nop", hz.fd_state, PIPE_NOP);
    chk("rst_mw_nop", hz.mw_state, PIPE_NOP);
    chk("rst_pc_en", hz.pc_en, 0);
    chk("rst_halt", hz.halt, 0);
    chk("rst_stall_cnt", hz.stall_cnt, 0);
    step(); step();
    nRST = 1'b1;

    // Load-use on rs, then rt_ex=0 (no hazard), then load-use on rt
    hz.dREN_ex = 1'b1; hz.rt_ex = 5'd5; hz.rs_dec = 5'd5;
    #1;
    chk("lu_fd_stall", hz.fd_state, PIPE_STALL);
    chk("lu_de_nop", hz.de_state, PIPE_NOP);
    chk("lu_pc_en", hz.pc_en, 0);
    step(); idle();
    chk("lu_stall_cnt", hz.stall_cnt, 1);
    hz.dREN_ex = 1'b1; hz.rt_ex = 5'd0; hz.rs_dec = 5'd0; hz.rt_dec = 5'd0;
    #1;
    chk("lu_r0_fd", hz.fd_state, PIPE_ENABLE);
    chk("lu_r0_pc_en", hz.pc_en, 1);
    step();
    hz.rt_ex = 5'd7; hz.rs_dec = 5'd3; hz.rt_dec = 5'd7;
    #1;
    chk("lu_rt_de_nop", hz.de_state, PIPE_NOP);
    step(); idle();
    chk("lu_rt_stall_cnt", hz.stall_cnt, 2);

    // Data wait for 3 cycles, resume on dhit; then one store wait cycle
    hz.dREN_mem = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("dw_mw_nop", hz.mw_state, PIPE_NOP);
      chk("dw_em_stall", hz.em_state, PIPE_STALL);
      chk("dw_pc_en", hz.pc_en, 0);
      step();
    end
    hz.dhit = 1'b1;
    #1;
    chk("dw_hit_mw", hz.mw_state, PIPE_ENABLE);
    chk("dw_hit_pc_en", hz.pc_en, 1);
    step(); idle();
    chk("dw_stall_cnt", hz.stall_cnt, 5);
    hz.dWEN_mem = 1'b1;
    #1;
    chk("sw_fd_stall", hz.fd_state, PIPE_STALL);
    step();
    hz.dhit = 1'b1;
    step(); idle();
    chk("sw_stall_cnt", hz.stall_cnt, 6);

    // Redirect with ihit
    hz.redirect_ex = 1'b1;
    #1;
    chk("rd_fd_nop", hz.fd_state, PIPE_NOP);
    chk("rd_de_nop", hz.de_state, PIPE_NOP);
    chk("rd_pc_en", hz.pc_en, 1);
    step(); idle();
    chk("rd_flush_cnt", hz.flush_cnt, 1);

    // Redirect straddling a fetch miss
    hz.redirect_ex = 1'b1; hz.ihit = 1'b0;
    #1;
    chk("rdw_first_pc_en", hz.pc_en, 1);
    step();
    hz.redirect_ex = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("rdw_wait_de_nop", hz.de_state, PIPE_NOP);
      chk("rdw_wait_pc_en", hz.pc_en, 0);
      step();
    end
    hz.ihit = 1'b1;
    #1;
    chk("rdw_hit_fd_nop", hz.fd_state, PIPE_NOP);
    chk("rdw_hit_pc_en", hz.pc_en, 1);
    step();
    #1;
    chk("rdw_run_fd", hz.fd_state, PIPE_ENABLE);
    chk("rdw_flush_cnt", hz.flush_cnt, 2);
    chk("rdw_stall_cnt", hz.stall_cnt, 6);

    // Redirect coinciding with data wait
    hz.redirect_ex = 1'b1; hz.dREN_mem = 1'b1;
    #1;
    chk("rddw_fd_stall", hz.fd_state, PIPE_STALL);
    chk("rddw_pc_en", hz.pc_en, 0);
    step();
    hz.dhit = 1'b1;
    #1;
    chk("rddw_hit_fd_nop", hz.fd_state, PIPE_NOP);
    chk("rddw_hit_pc_en", hz.pc_en, 1);
    step(); idle();
    chk("rddw_flush_cnt", hz.flush_cnt, 3);
    chk("rddw_stall_cnt", hz.stall_cnt, 7);

    // Fetch misses drive the stall counter into saturation
    hz.ihit = 1'b0;
    #1;
    chk("im_fd_nop", hz.fd_state, PIPE_NOP);
    chk("im_de_en", hz.de_state, PIPE_ENABLE);
    for (int i = 0; i < 11; i++) step();
    idle();
    chk("sat_stall_cnt", hz.stall_cnt, 15);

    // Halt behind a data wait, then drain and halt
    hz.halt_mem = 1'b1; hz.dREN_mem = 1'b1;
    #1;
    chk("hl_dw_fd_stall", hz.fd_state, PIPE_STALL);
    step();
    hz.dhit = 1'b1;
    #1;
    chk("hl_fd_nop", hz.fd_state, PIPE_NOP);
    chk("hl_em_en", hz.em_state, PIPE_ENABLE);
    chk("hl_pc_en", hz.pc_en, 0);
    step(); idle();
    chk("drn_em_nop", hz.em_state, PIPE_NOP);
    chk("drn_mw_en", hz.mw_state, PIPE_ENABLE);
    chk("drn_halt", hz.halt, 0);
    step();
    chk("hlt_halt", hz.halt, 1);
    chk("hlt_mw_stall", hz.mw_state, PIPE_STALL);
    hz.redirect_ex = 1'b1;
    #1;
    chk("hlt_rd_fd", hz.fd_state, PIPE_STALL);
    chk("hlt_rd_pc_en", hz.pc_en, 0);
    step(); step();
    chk("hlt_flush_cnt", hz.flush_cnt, 3);
    chk("hlt_stall_cnt", hz.stall_cnt, 15);

    // Asynchronous reset out of HALTED
    nRST = 1'b0;
    #1;
    chk("rh_halt", hz.halt, 0);
    chk("rh_stall_cnt", hz.stall_cnt, 0);
    chk("rh_flush_cnt", hz.flush_cnt, 0);
    chk("rh_fd_nop", hz.fd_state, PIPE_NOP);
    chk("rh_pc_en", hz.pc_en, 0);
    step(); idle();
    nRST = 1'b1;
    #1;
    chk("rh_run_fd", hz.fd_state, PIPE_ENABLE);
    chk("rh_run_pc_en", hz.pc_en, 1);
    step();

    // Asynchronous reset mid data wait
    hz.dREN_mem = 1'b1;
    step(); step();
    chk("rdw_pre_stall_cnt", hz.stall_cnt, 2);
    nRST = 1'b0;
    #1;
    chk("rdwt_stall_cnt", hz.stall_cnt, 0);
    chk("rdwt_em_nop", hz.em_state, PIPE_NOP);
    step(); idle();
    nRST = 1'b1;
    step();
    chk("rdwt_after_stall_cnt", hz.stall_cnt, 0);

    // Reset while a redirect waits on a fetch miss: no pending redirect survives
    hz.redirect_ex = 1'b1; hz.ihit = 1'b0;
    step();
    hz.redirect_ex = 1'b0;
    #1;
    chk("rrw_wait_de_nop", hz.de_state, PIPE_NOP);
    nRST = 1'b0;
    step();
    nRST = 1'b1;
    #1;
    chk("rrw_run_de_en", hz.de_state, PIPE_ENABLE);
    chk("rrw_run_fd_nop", hz.fd_state, PIPE_NOP);
    step(); idle();
    #1;
    chk("rrw_pc_en", hz.pc_en, 1);
    step(); step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Central pipeline controller for the five-stage MIPS datapath. Generates the per-latch advance commands (`PIPE_ENABLE` / `PIPE_STALL` / `PIPE_NOP`) consumed by the fetch-decode, decode-execute, execute-memory and memory-writeback latches, plus the PC enable. It resolves load-use hazards, taken-branch/jump flushes, instruction and data memory waits, and halt draining. A small FSM tracks redirects that straddle an instruction-fetch miss and the halt sequence.

## Interface
- `STALL_CNT_W`, default 32: width of the saturating stall/flush performance counters.
- `CLK`  in  1  system clock, rising edge.
- `nRST`  in  1  asynchronous, active-low reset.
- `ihit`  in  1  instruction memory returned the current fetch this cycle.
- `dhit`  in  1  data memory completed the MEM-stage access this cycle.
- `dREN_mem`, `dWEN_mem`  in  1 each  MEM-stage load/store request.
- `dREN_ex`  in  1  instruction in EX is a load.
- `rt_ex`  in  5  EX-stage load destination register.
- `rs_dec`, `rt_dec`  in  5 each  DEC-stage source registers.
- `redirect_ex`  in  1  EX resolved a taken branch or jump; the PC mux selects the target.
- `halt_mem`  in  1  halt instruction in MEM.
- `fd_state`, `de_state`, `em_state`, `mw_state`  out  pipe_state_t  latch commands.
- `pc_en`  out  1  PC register load enable.
- `halt`  out  1  sticky processor halt.
- `stall_cnt`, `flush_cnt`  out  STALL_CNT_W  performance counters.

## Operation
- FSM states: `HZ_RUN`, `HZ_REDIR_WAIT`, `HZ_DRAIN`, `HZ_HALTED`.
- Hazard conditions:
  - `dwait` = (dREN_mem | dWEN_mem) & !dhit.
  - `loaduse` = dREN_ex & rt_ex != 0 & (rt_ex == rs_dec | rt_ex == rt_dec).
- In `HZ_RUN`, the first matching rule below applies (strict priority):
  1. `dwait`: fd/de/em STALL; mw NOP; pc_en=0; stall_cnt++.
  2. `redirect_ex`: fd NOP; de NOP; em/mw ENABLE; pc_en=1; flush_cnt++. If !ihit in the same cycle, go to `HZ_REDIR_WAIT`.
  3. `loaduse`: fd STALL; de NOP; em/mw ENABLE; pc_en=0; stall_cnt++.
  4. `!ihit`: fd NOP; de/em/mw ENABLE; pc_en=0; stall_cnt++.
  5. Otherwise: all ENABLE; pc_en=1.
- `halt_mem` with !dwait: go to `HZ_DRAIN`. Outputs that cycle: fd/de NOP, em/mw ENABLE, pc_en=0.
- `HZ_REDIR_WAIT`:
  - Outputs: fd NOP, de NOP, em/mw ENABLE, pc_en=0.
  - `dwait` overrides, using the rule 1 outputs.
  - Return to `HZ_RUN` on ihit; pc_en=1 in that cycle.
- `HZ_DRAIN`: fd/de/em NOP, mw ENABLE, pc_en=0. Go to `HZ_HALTED` next cycle.
- `HZ_HALTED`: all four latches STALL, pc_en=0, halt=1. Only reset leaves this state.
- Counters saturate at all-ones. They never count in `HZ_DRAIN` or `HZ_HALTED`.

## Timing
- Latch commands and pc_en are combinational from the FSM state and the current inputs (zero latency). FSM state, counters and halt are registered.
- While nRST is low:
  - State `HZ_RUN`, halt=0, counters=0.
  - Outputs are forced to all four latches NOP and pc_en=0.
- The first rising edge after nRST is released evaluates normally.
- A reset asserted mid-stall or mid-drain returns to `HZ_RUN` asynchronously. No redirect pending state survives reset.
- `dwait` coinciding with `redirect_ex`: the redirect is held in EX by the stall and is taken on the cycle dhit arrives.
- `halt_mem` coinciding with `dwait`: drain starts only after dhit.
- halt rises one cycle after entry to `HZ_DRAIN` and stays high.

## Structure
- `cpu_types_pkg` holds `pipe_state_t` (`PIPE_ENABLE`, `PIPE_STALL`, `PIPE_NOP`) and a new `hz_state_t` enum.
- One sub-module, `hazard_perf_counter`: a parameterised saturating counter with increment enable. Instantiated twice.

## Test plan
- Load `lw $5` in EX with `add` in DEC reading `$5`: de NOP, fd STALL, pc_en=0 for 1 cycle, stall_cnt=1. Same sequence with rt_ex=0: no stall.
- dREN_mem=1, dhit low for 3 cycles: mw NOP, others STALL for 3 cycles, stall_cnt=3. ENABLE resumes on the dhit cycle.
- redirect_ex with ihit=1: fd/de NOP for 1 cycle, pc_en=1, flush_cnt=1.
- redirect_ex with ihit low for 2 cycles: `HZ_REDIR_WAIT` for 2 cycles with fd/de NOP and pc_en=0, then `HZ_RUN` with pc_en=1 on ihit.
- halt_mem asserted: pc_en=0 immediately, halt=1 two edges later, all STALL. A subsequent redirect_ex is ignored.
- nRST pulsed low in `HZ_HALTED` and mid-dwait: halt=0, counters=0 and outputs NOP immediately (asynchronously). Force stall_cnt to all-ones and stall again: the value holds.
